// File: rtl/axis_arb_pkg.sv
// rtl/axis_arb_pkg.sv - shared state type, counter width and round-robin helper for axis_rr_arbiter
package axis_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int PKT_CNT_W = 16;

  // Index that follows idx on a ring of n entries.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/axis_rr_arbiter_if.sv
// rtl/axis_rr_arbiter_if.sv - N-source stream bundle plus merged output stream
interface axis_rr_arbiter_if #(
  parameter int N_BYTES = 4,
  parameter int N_SRC   = 4
);
  localparam int SRC_W = $clog2(N_SRC);

  logic [N_SRC-1:0]           s_tvalid;
  logic [N_SRC-1:0]           s_tready;
  logic [N_SRC*8*N_BYTES-1:0] s_tdata;
  logic [N_SRC*N_BYTES-1:0]   s_tstrb;
  logic [N_SRC*N_BYTES-1:0]   s_tkeep;
  logic [N_SRC-1:0]           s_tlast;

  logic                       m_tvalid;
  logic                       m_tready;
  logic [8*N_BYTES-1:0]       m_tdata;
  logic [N_BYTES-1:0]         m_tstrb;
  logic [N_BYTES-1:0]         m_tkeep;
  logic                       m_tlast;
  logic [SRC_W-1:0]           m_tid;

  // Environment side: drives the sources and the output sink ready.
  modport master (
    output s_tvalid, s_tdata, s_tstrb, s_tkeep, s_tlast, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid
  );

  // Arbiter side.
  modport slave (
    input  s_tvalid, s_tdata, s_tstrb, s_tkeep, s_tlast, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid
  );
endinterface

// File: rtl/rr_select.sv
// rtl/rr_select.sv - combinational round-robin priority search over request vector
module rr_select
  import axis_arb_pkg::*;
#(
  parameter  int N_SRC = 4,
  localparam int SRC_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [SRC_W-1:0] last,
  output logic [SRC_W-1:0] idx,
  output logic             found
);

  logic [SRC_W-1:0] cand;

  // Walk the ring starting just after the last winner; the first requester found wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = last;
    for (int k = 0; k < N_SRC; k++) begin
      cand = SRC_W'(rr_next(32'(cand), N_SRC));
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// rtl/axis_rr_arbiter.sv - packet round-robin stream arbiter; optional m_tid via AXIS_RR_ARBITER_TID_EN
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int N_BYTES = 4,
  parameter  int N_SRC   = 4,
  localparam int SRC_W   = $clog2(N_SRC)
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  axis_rr_arbiter_if.slave     bus,
  output logic [SRC_W-1:0]     grant,
  output logic                 busy,
  output logic [PKT_CNT_W-1:0] pkt_count
);

  localparam int DW = 8 * N_BYTES;

  state_t               state_q, state_d;
  logic [SRC_W-1:0]     grant_q, grant_d;
  logic [SRC_W-1:0]     last_grant_q, last_grant_d;
  logic [PKT_CNT_W-1:0] pkt_count_q, pkt_count_d;

  logic [SRC_W-1:0]     sel_idx;
  logic                 sel_found;
  logic                 xfer_last;

  rr_select #(.N_SRC(N_SRC)) u_rr_select (
    .req   (bus.s_tvalid),
    .last  (last_grant_q),
    .idx   (sel_idx),
    .found (sel_found)
  );

  // Route the granted source straight through while BUSY; all outputs are zero in IDLE.
  always_comb begin
    bus.m_tvalid = 1'b0;
    bus.s_tready = '0;
    bus.m_tdata  = '0;
    bus.m_tstrb  = '0;
    bus.m_tkeep  = '0;
    bus.m_tlast  = 1'b0;
    if (state_q == BUSY) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (SRC_W'(i) == grant_q) begin
          bus.m_tvalid    = bus.s_tvalid[i];
          bus.s_tready[i] = bus.m_tready;
          bus.m_tdata     = bus.s_tdata[i*DW +: DW];
          bus.m_tstrb     = bus.s_tstrb[i*N_BYTES +: N_BYTES];
          bus.m_tkeep     = bus.s_tkeep[i*N_BYTES +: N_BYTES];
          bus.m_tlast     = bus.s_tlast[i];
        end
      end
    end
  end

  assign xfer_last = (state_q == BUSY) && bus.m_tvalid && bus.m_tready && bus.m_tlast;

  // Arbitrate in IDLE, hold the grant until the tlast beat, then drop back for one bubble cycle.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    pkt_count_d  = pkt_count_q;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          grant_d      = sel_idx;
          last_grant_d = sel_idx;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        if (xfer_last) begin
          state_d     = IDLE;
          pkt_count_d = pkt_count_q + PKT_CNT_W'(1);
        end
      end
    endcase
  end

  // State registers; last_grant resets to the top index so source 0 wins first.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= SRC_W'(N_SRC - 1);
      pkt_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      pkt_count_q  <= pkt_count_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q == BUSY);
  assign pkt_count = pkt_count_q;

`ifdef AXIS_RR_ARBITER_TID_EN
  assign bus.m_tid = (state_q == BUSY) ? grant_q : '0;
`else
  assign bus.m_tid = '0;
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb/tb_axis_rr_arbiter.sv - vector table plus scoreboard bench for axis_rr_arbiter
module tb_axis_rr_arbiter;

  localparam int NB = 4;
  localparam int NS = 4;
  localparam int DW = 8 * NB;

`ifdef AXIS_RR_ARBITER_TID_EN
  localparam logic TID_ON = 1'b1;
`else
  localparam logic TID_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [1:0]  grant;
  logic        busy;
  logic [15:0] pkt_count;
  int          total = 0;
  int          bad = 0;

  axis_rr_arbiter_if #(.N_BYTES(NB), .N_SRC(NS)) bus ();

  axis_rr_arbiter #(.N_BYTES(NB), .N_SRC(NS)) dut (
    .aclk      (clk),
    .aresetn   (aresetn),
    .bus       (bus.slave),
    .grant     (grant),
    .busy      (busy),
    .pkt_count (pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    logic        rstn;
    logic [3:0]  vld;
    logic [3:0]  last;
    logic        rdy;
    logic        mv;
    logic        bsy;
    logic [1:0]  g;
    logic [3:0]  srdy;
    logic [15:0] cnt;
  } vec_t;

  beat_t sb[$];
  vec_t  vt[17];

  function automatic logic [31:0] src_data(input int i, input int k);
    return {8'(8'hC0 + i), 8'(k), 16'(k * 37 + i * 5)};
  endfunction

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [3:0] l, input logic rd,
                              input logic mv, input logic b, input logic [1:0] g, input logic [3:0] s,
                              input logic [15:0] c);
    vec_t x;
    x.rstn = r; x.vld = v; x.last = l; x.rdy = rd;
    x.mv = mv; x.bsy = b; x.g = g; x.srdy = s; x.cnt = c;
    return x;
  endfunction

  task automatic drive_src(input int i, input logic v, input logic l, input int k);
    bus.s_tvalid[i]           = v;
    bus.s_tlast[i]            = l;
    bus.s_tdata[i*DW +: DW]   = src_data(i, k);
    bus.s_tstrb[i*NB +: NB]   = 4'(i + 1);
    bus.s_tkeep[i*NB +: NB]   = 4'hF ^ 4'(i);
  endtask

  task automatic idle_all();
    for (int i = 0; i < NS; i++) drive_src(i, 1'b0, 1'b0, 0);
  endtask

  task automatic push_exp(input int i, input logic l, input int k);
    beat_t b;
    b.data = src_data(i, k);
    b.strb = 4'(i + 1);
    b.keep = 4'hF ^ 4'(i);
    b.last = l;
    sb.push_back(b);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic reset_dut();
    aresetn = 1'b0;
    cyc();
    aresetn = 1'b1;
  endtask

  // Scoreboard consumer: every accepted output beat must match the oldest expected beat.
  always @(negedge clk) begin
    beat_t e;
    if (aresetn && bus.m_tvalid && bus.m_tready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got data %0h expected no beat", bus.m_tdata);
      end else begin
        e = sb.pop_front();
        chk("beat_data", bus.m_tdata, e.data);
        chk("beat_strb", 32'(bus.m_tstrb), 32'(e.strb));
        chk("beat_keep", 32'(bus.m_tkeep), 32'(e.keep));
        chk("beat_last", 32'(bus.m_tlast), 32'(e.last));
      end
    end
  end

  logic [5:0]  pat = 6'b111001;
  int          b;
  logic [15:0] exp_cnt;

  initial begin
    // single 3-beat packet from source 2
    vt[0]  = mk(1, 4'b0100, 4'b0000, 1, 0, 0, 2'd0, 4'b0000, 16'd0);
    vt[1]  = mk(1, 4'b0100, 4'b0000, 1, 1, 1, 2'd2, 4'b0100, 16'd0);
    vt[2]  = mk(1, 4'b0100, 4'b0000, 1, 1, 1, 2'd2, 4'b0100, 16'd0);
    vt[3]  = mk(1, 4'b0100, 4'b0100, 1, 1, 1, 2'd2, 4'b0100, 16'd0);
    vt[4]  = mk(1, 4'b0000, 4'b0000, 1, 0, 0, 2'd2, 4'b0000, 16'd1);
    // reset, then all sources stream 1-beat packets
    vt[5]  = mk(0, 4'b0000, 4'b0000, 1, 0, 0, 2'd2, 4'b0000, 16'd1);
    vt[6]  = mk(1, 4'b1111, 4'b1111, 1, 0, 0, 2'd0, 4'b0000, 16'd0);
    vt[7]  = mk(1, 4'b1111, 4'b1111, 1, 1, 1, 2'd0, 4'b0001, 16'd0);
    vt[8]  = mk(1, 4'b1111, 4'b1111, 1, 0, 0, 2'd0, 4'b0000, 16'd1);
    vt[9]  = mk(1, 4'b1111, 4'b1111, 1, 1, 1, 2'd1, 4'b0010, 16'd1);
    vt[10] = mk(1, 4'b1111, 4'b1111, 1, 0, 0, 2'd1, 4'b0000, 16'd2);
    vt[11] = mk(1, 4'b1111, 4'b1111, 1, 1, 1, 2'd2, 4'b0100, 16'd2);
    vt[12] = mk(1, 4'b1111, 4'b1111, 1, 0, 0, 2'd2, 4'b0000, 16'd3);
    vt[13] = mk(1, 4'b1111, 4'b1111, 1, 1, 1, 2'd3, 4'b1000, 16'd3);
    vt[14] = mk(1, 4'b1111, 4'b1111, 1, 0, 0, 2'd3, 4'b0000, 16'd4);
    vt[15] = mk(1, 4'b1111, 4'b1111, 1, 1, 1, 2'd0, 4'b0001, 16'd4);
    vt[16] = mk(1, 4'b0000, 4'b0000, 1, 0, 0, 2'd0, 4'b0000, 16'd5);

    idle_all();
    bus.m_tready = 1'b0;
    aresetn = 1'b0;
    cyc();
    cyc();
    settle();
    chk("rst_m_tvalid", 32'(bus.m_tvalid), 32'd0);
    chk("rst_s_tready", 32'(bus.s_tready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    chk("rst_m_tid", 32'(bus.m_tid), 32'd0);
    chk("rst_m_tdata", bus.m_tdata, 32'd0);

    for (int k = 0; k < 17; k++) begin
      aresetn = vt[k].rstn;
      bus.m_tready = vt[k].rdy;
      for (int i = 0; i < NS; i++) drive_src(i, vt[k].vld[i], vt[k].last[i], k);
      settle();
      chk($sformatf("v%0d_m_tvalid", k), 32'(bus.m_tvalid), 32'(vt[k].mv));
      chk($sformatf("v%0d_busy", k), 32'(busy), 32'(vt[k].bsy));
      chk($sformatf("v%0d_grant", k), 32'(grant), 32'(vt[k].g));
      chk($sformatf("v%0d_s_tready", k), 32'(bus.s_tready), 32'(vt[k].srdy));
      chk($sformatf("v%0d_pkt_count", k), 32'(pkt_count), 32'(vt[k].cnt));
      if (vt[k].rstn && vt[k].mv && vt[k].rdy) push_exp(int'(vt[k].g), vt[k].last[vt[k].g], k);
      cyc();
    end
    aresetn = 1'b1;

    // backpressure on source 1 while source 3 waits
    idle_all();
    reset_dut();
    bus.m_tready = 1'b1;
    drive_src(1, 1'b1, 1'b0, 200);
    drive_src(3, 1'b1, 1'b1, 300);
    settle();
    chk("bp_idle_m_tvalid", 32'(bus.m_tvalid), 32'd0);
    cyc();
    b = 0;
    for (int c = 0; c < 6; c++) begin
      bus.m_tready = pat[c];
      drive_src(1, 1'b1, (b == 3), 200 + b);
      settle();
      chk($sformatf("bp%0d_grant", c), 32'(grant), 32'd1);
      chk($sformatf("bp%0d_s_tready1", c), 32'(bus.s_tready[1]), 32'(pat[c]));
      chk($sformatf("bp%0d_s_tready3", c), 32'(bus.s_tready[3]), 32'd0);
      chk($sformatf("bp%0d_m_tvalid", c), 32'(bus.m_tvalid), 32'd1);
      if (pat[c]) begin
        push_exp(1, (b == 3), 200 + b);
        b++;
      end
      cyc();
    end
    drive_src(1, 1'b0, 1'b0, 0);
    bus.m_tready = 1'b1;
    settle();
    chk("bp_bubble_busy", 32'(busy), 32'd0);
    chk("bp_bubble_m_tvalid", 32'(bus.m_tvalid), 32'd0);
    cyc();
    settle();
    chk("bp_next_grant", 32'(grant), 32'd3);
    chk("bp_next_busy", 32'(busy), 32'd1);
    push_exp(3, 1'b1, 300);
    cyc();
    idle_all();
    settle();
    chk("bp_pkt_count", 32'(pkt_count), 32'd2);
    cyc();

    // reset in the middle of a 5-beat packet from source 3
    reset_dut();
    bus.m_tready = 1'b1;
    drive_src(3, 1'b1, 1'b0, 400);
    cyc();
    settle();
    chk("mr_grant", 32'(grant), 32'd3);
    push_exp(3, 1'b0, 400);
    cyc();
    drive_src(3, 1'b1, 1'b0, 401);
    aresetn = 1'b0;
    cyc();
    aresetn = 1'b1;
    for (int i = 0; i < NS; i++) drive_src(i, 1'b1, 1'b1, 500 + i);
    settle();
    chk("mr_m_tvalid", 32'(bus.m_tvalid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_pkt_count", 32'(pkt_count), 32'd0);
    cyc();
    settle();
    chk("mr_next_grant", 32'(grant), 32'd0);
    chk("mr_next_busy", 32'(busy), 32'd1);
    push_exp(0, 1'b1, 500);
    cyc();
    idle_all();
    cyc();

    // counter wrap: jump near the top, then run three 1-beat packets
    force dut.pkt_count_q = 16'hFFFD;
    #1;
    release dut.pkt_count_q;
    cyc();
    exp_cnt = 16'hFFFD;
    for (int p = 0; p < 3; p++) begin
      drive_src(0, 1'b1, 1'b1, 600 + p);
      cyc();
      settle();
      push_exp(0, 1'b1, 600 + p);
      cyc();
      idle_all();
      exp_cnt = exp_cnt + 16'd1;
      settle();
      chk($sformatf("wrap%0d_pkt_count", p), 32'(pkt_count), 32'(exp_cnt));
      cyc();
    end

    // m_tid with source 2 granted
    reset_dut();
    drive_src(2, 1'b1, 1'b1, 700);
    settle();
    chk("tid_idle", 32'(bus.m_tid), 32'd0);
    cyc();
    settle();
    chk("tid_grant", 32'(grant), 32'd2);
    chk("tid_busy", 32'(bus.m_tid), TID_ON ? 32'd2 : 32'd0);
    push_exp(2, 1'b1, 700);
    cyc();
    idle_all();
    cyc();
    cyc();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
